// File: rtl/ftb_update_sched_if.sv
// Port bundle between the FTQ update path, the prediction lookup arbiter and the
// FTB SRAM, as seen by the update scheduler.
interface ftb_update_sched_if #(
  parameter int ADDR_W  = 64,
  parameter int SETS    = 512,
  parameter int WAYS    = 4,
  parameter int TAG_W   = 20,
  parameter int ENTRY_W = 48
) ();
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic                    i_update_vld;
  logic [ADDR_W-1:0]       i_update_startAddr;
  logic [ENTRY_W-1:0]      i_update_entry;
  logic                    o_update_busy;
  logic                    o_update_finished;
  logic                    i_pred_lookup_req;
  logic                    o_pred_stall;
  logic                    o_sram_rd_en;
  logic [IDX_W-1:0]        o_sram_rd_set;
  logic [WAYS*TAG_W-1:0]   i_sram_rd_tags;
  logic [WAYS-1:0]         i_sram_rd_valids;
  logic                    o_sram_wr_en;
  logic [IDX_W-1:0]        o_sram_wr_set;
  logic [WAY_W-1:0]        o_sram_wr_way;
  logic [TAG_W-1:0]        o_sram_wr_tag;
  logic [ENTRY_W-1:0]      o_sram_wr_data;

  modport slave (
    input  i_update_vld, i_update_startAddr, i_update_entry,
    input  i_pred_lookup_req, i_sram_rd_tags, i_sram_rd_valids,
    output o_update_busy, o_update_finished, o_pred_stall,
    output o_sram_rd_en, o_sram_rd_set,
    output o_sram_wr_en, o_sram_wr_set, o_sram_wr_way, o_sram_wr_tag, o_sram_wr_data
  );

  modport master (
    output i_update_vld, i_update_startAddr, i_update_entry,
    output i_pred_lookup_req, i_sram_rd_tags, i_sram_rd_valids,
    input  o_update_busy, o_update_finished, o_pred_stall,
    input  o_sram_rd_en, o_sram_rd_set,
    input  o_sram_wr_en, o_sram_wr_set, o_sram_wr_way, o_sram_wr_tag, o_sram_wr_data
  );
endinterface

// File: rtl/ftb_update_sched.sv
// FTB update scheduler: read-tag / compare / write sequencing of one committed update
// into the single-ported FTB SRAM, with lookup-priority arbitration and a starvation bound.
module ftb_update_sched #(
  parameter int ADDR_W     = 64,
  parameter int SETS       = 512,
  parameter int WAYS       = 4,
  parameter int TAG_W      = 20,
  parameter int ENTRY_W    = 48,
  parameter int STARVE_LIM = 4
) (
  input logic               clk,
  input logic               rst,
  ftb_update_sched_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CMP   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     set_q, set_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [ENTRY_W-1:0]   entry_q, entry_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic                 miss_q, miss_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic [WAY_W-1:0]     victim_q, victim_d;

  logic                 port_win_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic                 stall_s;
  logic [WAY_W:0]       hit_s;
  logic                 unused_addr_s;

  // Lowest-index valid way whose tag matches; MSB flags a hit.
  function automatic logic [WAY_W:0] find_hit(
    input logic [WAYS*TAG_W-1:0] tags,
    input logic [WAYS-1:0]       valids,
    input logic [TAG_W-1:0]      tag
  );
    logic [WAY_W:0] res;
    res = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valids[w] && (tags[w*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, WAY_W'(w)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign hit_s = find_hit(bus.i_sram_rd_tags, bus.i_sram_rd_valids, tag_q);

  // Only the set and tag fields of the start address are meaningful here.
  assign unused_addr_s = ^{bus.i_update_startAddr[ADDR_W-1:1+IDX_W+TAG_W],
                           bus.i_update_startAddr[0]};

  // Next-state, arbitration and strobe generation.
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    tag_d      = tag_q;
    entry_d    = entry_q;
    way_d      = way_q;
    miss_d     = miss_q;
    starve_d   = starve_q;
    victim_d   = victim_q;
    rd_en_s    = 1'b0;
    wr_en_s    = 1'b0;
    stall_s    = 1'b0;
    // Lookups win unless the update has already lost STARVE_LIM times in a row.
    port_win_s = (!bus.i_pred_lookup_req) || (starve_q == CNT_W'(STARVE_LIM));

    case (state_q)
      ST_IDLE: begin
        if (bus.i_update_vld) begin
          set_d   = bus.i_update_startAddr[1 +: IDX_W];
          tag_d   = bus.i_update_startAddr[1+IDX_W +: TAG_W];
          entry_d = bus.i_update_entry;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (port_win_s) begin
          rd_en_s  = 1'b1;
          stall_s  = bus.i_pred_lookup_req;
          starve_d = '0;
          state_d  = ST_CMP;
        end else begin
          starve_d = starve_q + CNT_W'(1);
          state_d  = ST_READ;
        end
      end
      ST_CMP: begin
        if (hit_s[WAY_W]) begin
          way_d  = hit_s[WAY_W-1:0];
          miss_d = 1'b0;
        end else begin
          way_d  = victim_q;
          miss_d = 1'b1;
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (port_win_s) begin
          wr_en_s  = 1'b1;
          stall_s  = bus.i_pred_lookup_req;
          starve_d = '0;
          state_d  = ST_IDLE;
          if (miss_q) begin
            victim_d = victim_q + WAY_W'(1);
          end else begin
            victim_d = victim_q;
          end
        end else begin
          starve_d = starve_q + CNT_W'(1);
          state_d  = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      set_q    <= '0;
      tag_q    <= '0;
      entry_q  <= '0;
      way_q    <= '0;
      miss_q   <= 1'b0;
      starve_q <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      tag_q    <= tag_d;
      entry_q  <= entry_d;
      way_q    <= way_d;
      miss_q   <= miss_d;
      starve_q <= starve_d;
      victim_q <= victim_d;
    end
  end

  assign bus.o_update_busy     = (state_q != ST_IDLE);
  assign bus.o_update_finished = wr_en_s;
  assign bus.o_pred_stall      = stall_s;
  assign bus.o_sram_rd_en      = rd_en_s;
  assign bus.o_sram_rd_set     = set_q;
  assign bus.o_sram_wr_en      = wr_en_s;
  assign bus.o_sram_wr_set     = set_q;
  assign bus.o_sram_wr_way     = way_q;
  assign bus.o_sram_wr_tag     = tag_q;
  assign bus.o_sram_wr_data    = entry_q;
endmodule

// Protocol properties of the scheduler; en_i masks the request-while-busy check.
module ftb_update_sched_chk (
  input logic clk,
  input logic rst,
  input logic en_i,
  input logic update_vld_i,
  input logic update_busy_i,
  input logic rd_en_i,
  input logic wr_en_i,
  input logic finished_i
);
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (rst || !en_i)
    !(update_vld_i && update_busy_i))
    else $error("update request while scheduler busy");

  a_port_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(rd_en_i && wr_en_i))
    else $error("read and write strobes together");

  a_finish_with_write: assert property (@(posedge clk) disable iff (rst)
    (finished_i == wr_en_i))
    else $error("finished pulse not aligned with write");
endmodule

// File: tb/tb_ftb_update_sched.sv
// Bench for ftb_update_sched: directed scenarios plus randomized traffic checked each
// cycle against a transaction-level schedule/array model.
module tb_ftb_update_sched;
  localparam int ADDR_W = 64, SETS = 512, WAYS = 4, TAG_W = 20, ENTRY_W = 48;
  localparam int STARVE_LIM = 4;
  localparam int IDX_W = 9, NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b1;
  always #5 clk = ~clk;

  ftb_update_sched_if #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W),
                        .ENTRY_W(ENTRY_W)) bus ();

  ftb_update_sched #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W),
                     .ENTRY_W(ENTRY_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ftb_update_sched_chk chk (
    .clk(clk), .rst(rst), .en_i(chk_en),
    .update_vld_i(bus.i_update_vld), .update_busy_i(bus.o_update_busy),
    .rd_en_i(bus.o_sram_rd_en), .wr_en_i(bus.o_sram_wr_en),
    .finished_i(bus.o_update_finished)
  );

  // Model of the FTB array contents and the global victim pointer.
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  bit               m_v   [SETS][WAYS];
  int               m_victim = 0;

  // Per-cycle stimulus and expectations.
  bit                    req_pat [NCYC];
  logic [WAYS*TAG_W-1:0] tag_drv [NCYC];
  logic [WAYS-1:0]       vld_drv [NCYC];
  bit                    e_busy [NCYC], e_rd [NCYC], e_wr [NCYC], e_stall [NCYC];
  int                    e_set [NCYC], e_way [NCYC];
  logic [TAG_W-1:0]      e_tag [NCYC];
  logic [ENTRY_W-1:0]    e_data [NCYC];

  int cyc = 0;
  int vectors = 0, errors = 0;
  int last_rd_cyc = -1, last_wr_cyc = -1, last_wr_way = -1;
  int busy_end = 0;
  int i_T, i_rd, i_wr, i_set, i_way;
  bit i_hit, i_old_v;
  logic [TAG_W-1:0] i_old_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Single per-cycle compare process.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      chk_val("busy", bus.o_update_busy, e_busy[cyc]);
      chk_val("rd_en", bus.o_sram_rd_en, e_rd[cyc]);
      chk_val("wr_en", bus.o_sram_wr_en, e_wr[cyc]);
      chk_val("finished", bus.o_update_finished, e_wr[cyc]);
      chk_val("pred_stall", bus.o_pred_stall, e_stall[cyc]);
      if (e_rd[cyc]) chk_val("rd_set", bus.o_sram_rd_set, e_set[cyc]);
      if (e_wr[cyc]) begin
        chk_val("wr_set", bus.o_sram_wr_set, e_set[cyc]);
        chk_val("wr_way", bus.o_sram_wr_way, e_way[cyc]);
        chk_val("wr_tag", bus.o_sram_wr_tag, e_tag[cyc]);
        chk_val("wr_data", bus.o_sram_wr_data, e_data[cyc]);
      end
      if (bus.o_sram_rd_en === 1'b1) last_rd_cyc = cyc;
      if (bus.o_sram_wr_en === 1'b1) begin
        last_wr_cyc = cyc;
        last_wr_way = int'(bus.o_sram_wr_way);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] mk_addr(input int s, input int t);
    logic [ADDR_W-1:0] a;
    a = {$urandom, $urandom};
    a[1 +: IDX_W] = s[IDX_W-1:0];
    a[1+IDX_W +: TAG_W] = t[TAG_W-1:0];
    return a;
  endfunction

  function automatic logic [ENTRY_W-1:0] rnd_entry();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[ENTRY_W-1:0];
  endfunction

  // Advance one cycle and drive background inputs for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_update_vld       = 1'b0;
    bus.i_update_startAddr = {$urandom, $urandom};
    bus.i_update_entry     = rnd_entry();
    bus.i_pred_lookup_req  = req_pat[cyc];
    bus.i_sram_rd_tags     = tag_drv[cyc];
    bus.i_sram_rd_valids   = vld_drv[cyc];
  endtask

  task automatic quiet(input int n);
    for (int c = cyc + 1; c <= cyc + n; c++) req_pat[c] = 1'b0;
  endtask

  // Issue an update this cycle and derive its whole schedule and write target.
  task automatic issue(input logic [ADDR_W-1:0] addr, input logic [ENTRY_W-1:0] entry);
    int c, w0, s;
    logic [TAG_W-1:0] t;
    i_T = cyc;
    bus.i_update_vld       = 1'b1;
    bus.i_update_startAddr = addr;
    bus.i_update_entry     = entry;
    s = int'(addr[1 +: IDX_W]);
    t = addr[1+IDX_W +: TAG_W];
    c = i_T + 1;
    while (req_pat[c] && (c - (i_T + 1)) < STARVE_LIM) c++;
    i_rd = c;
    w0 = i_rd + 2;
    c = w0;
    while (req_pat[c] && (c - w0) < STARVE_LIM) c++;
    i_wr = c;
    i_hit = 1'b0;
    i_way = m_victim;
    for (int w = 0; w < WAYS; w++) begin
      if (!i_hit && m_v[s][w] && m_tag[s][w] == t) begin
        i_hit = 1'b1;
        i_way = w;
      end
    end
    if (!i_hit) m_victim = (m_victim + 1) % WAYS;
    for (int w = 0; w < WAYS; w++) begin
      tag_drv[i_rd+1][w*TAG_W +: TAG_W] = m_tag[s][w];
      vld_drv[i_rd+1][w] = m_v[s][w];
    end
    i_set = s;
    i_old_tag = m_tag[s][i_way];
    i_old_v = m_v[s][i_way];
    m_tag[s][i_way] = t;
    m_v[s][i_way] = 1'b1;
    for (int k = i_T + 1; k <= i_wr; k++) e_busy[k] = 1'b1;
    e_rd[i_rd] = 1'b1;
    e_stall[i_rd] = req_pat[i_rd];
    e_set[i_rd] = s;
    e_wr[i_wr] = 1'b1;
    e_stall[i_wr] = req_pat[i_wr];
    e_set[i_wr] = s;
    e_way[i_wr] = i_way;
    e_tag[i_wr] = t;
    e_data[i_wr] = entry;
    busy_end = i_wr;
  endtask

  task automatic drain();
    while (cyc <= busy_end) tick();
  endtask

  task automatic set_way(input int s, input int w, input int t, input bit v);
    m_tag[s][w] = t[TAG_W-1:0];
    m_v[s][w] = v;
  endtask

  initial begin
    int pct, ta, tb_;
    logic [95:0] r96;
    logic [31:0] r32;
    for (int c = 0; c < NCYC; c++) begin
      if (c % 40 == 0) begin
        r32 = $urandom;
        pct = (r32[1:0] == 2'd0) ? 0 : (r32[1:0] == 2'd1) ? 30 : (r32[1:0] == 2'd2) ? 70 : 100;
      end
      req_pat[c] = ($urandom_range(0, 99) < pct);
      r96 = {$urandom, $urandom, $urandom};
      tag_drv[c] = r96[WAYS*TAG_W-1:0];
      r32 = $urandom;
      vld_drv[c] = r32[WAYS-1:0];
      e_busy[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_stall[c] = 0;
      e_set[c] = 0; e_way[c] = 0; e_tag[c] = '0; e_data[c] = '0;
    end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) set_way(s, w, 0, 1'b0);
    for (int s = 16; s < 24; s++)
      for (int w = 0; w < WAYS; w++) set_way(s, w, $urandom_range(0, 5), $urandom_range(0, 1) == 1);

    bus.i_update_vld = 1'b0;
    bus.i_update_startAddr = '0;
    bus.i_update_entry = '0;
    bus.i_pred_lookup_req = 1'b0;
    bus.i_sram_rd_tags = '0;
    bus.i_sram_rd_valids = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Hit on way 2 (way 1 matches but is invalid), idle port.
    set_way(5, 0, 'h111, 1'b1); set_way(5, 1, 'h123, 1'b0);
    set_way(5, 2, 'h123, 1'b1); set_way(5, 3, 'h124, 1'b1);
    quiet(12);
    issue(mk_addr(5, 'h123), rnd_entry());
    ta = i_T;
    chk_val("model_hit_way", i_way, 2);
    drain();
    chk_val("hit_rd_cycle", last_rd_cyc, ta + 1);
    chk_val("hit_wr_cycle", last_wr_cyc, ta + 3);
    chk_val("hit_wr_way", last_wr_way, 2);

    // Multi-hit: ways 1 and 3 match.
    set_way(6, 0, 'h200, 1'b1); set_way(6, 1, 'h300, 1'b1);
    set_way(6, 2, 'h301, 1'b1); set_way(6, 3, 'h300, 1'b1);
    tick(); quiet(12);
    issue(mk_addr(6, 'h300), rnd_entry());
    drain();
    chk_val("multihit_way", last_wr_way, 1);

    // Five misses walk the victim pointer through all ways and wrap.
    for (int k = 0; k < 5; k++) begin
      quiet(12);
      issue(mk_addr(8, 'h400 + k), rnd_entry());
      drain();
      if (k == 3) chk_val("miss_way3", last_wr_way, 3);
      if (k == 4) chk_val("miss_wrap_way0", last_wr_way, 0);
    end

    // Starvation in both READ and WRITE.
    for (int c = cyc + 1; c <= cyc + 20; c++) req_pat[c] = 1'b1;
    issue(mk_addr(5, 'h123), rnd_entry());
    ta = i_T;
    drain();
    chk_val("starve_rd_cycle", last_rd_cyc, ta + 5);
    chk_val("starve_wr_cycle", last_wr_cyc, ta + 11);

    // Reset while in CMP aborts the write and clears the victim pointer.
    tick(); quiet(12);
    issue(mk_addr(10, 'h555), rnd_entry());
    ta = i_T;
    tick();
    tick();
    rst = 1'b1;
    for (int c = ta + 3; c <= i_wr; c++) begin
      e_busy[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_stall[c] = 0;
    end
    m_tag[i_set][i_way] = i_old_tag;
    m_v[i_set][i_way] = i_old_v;
    m_victim = 0;
    busy_end = ta + 2;
    tick();
    rst = 1'b0;
    tick(); quiet(12);
    issue(mk_addr(9, 'h600), rnd_entry());
    ta = i_T;
    drain();
    chk_val("post_rst_wr_cycle", last_wr_cyc, ta + 3);
    chk_val("post_rst_victim_way", last_wr_way, 0);

    // Back-to-back with an ignored request while busy.
    tick(); quiet(20);
    issue(mk_addr(11, 'h700), rnd_entry());
    ta = i_T;
    tick();
    tick();
    chk_en = 1'b0;
    bus.i_update_vld = 1'b1;
    bus.i_update_startAddr = mk_addr(12, 'h7ff);
    tick();
    chk_en = 1'b1;
    tick();
    issue(mk_addr(11, 'h701), rnd_entry());
    tb_ = i_T;
    drain();
    chk_val("b2b_accept_cycle", tb_, ta + 4);
    chk_val("b2b_rd_cycle", last_rd_cyc, ta + 5);

    // Randomized traffic over a small set/tag pool so hits and misses both occur.
    while (cyc < NCYC - 40) begin
      tick();
      if (cyc > busy_end && $urandom_range(0, 2) == 0)
        issue(mk_addr(16 + $urandom_range(0, 7), $urandom_range(0, 5)), rnd_entry());
    end
    drain();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
